// File: rtl/io_periph_pkg.sv
// io_periph_pkg: register addresses, UART state encoding and UART_STAT bit positions for io_periph
package io_periph_pkg;
  localparam logic [15:0] IO_CYCLE      = 16'h00;
  localparam logic [15:0] IO_TIMER_CMP  = 16'h04;
  localparam logic [15:0] IO_TIMER_CTRL = 16'h08;
  localparam logic [15:0] IO_TIMER_CNT  = 16'h0C;
  localparam logic [15:0] IO_UART_DATA  = 16'h10;
  localparam logic [15:0] IO_UART_STAT  = 16'h14;
  localparam logic [15:0] IO_UART_DIV   = 16'h18;
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_CNT   = 4;
  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;
endpackage

// File: rtl/io_periph_fifo.sv
// sync_fifo: WIDTH x DEPTH FIFO (push/pop/din in; dout/full/empty/count out), drops push when full, ignores pop when empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/io_periph.sv
// io_periph: I/O bus target (io_r/io_w/io_addr/io_wdata in, io_rdata out) with cycle counter, compare timer (irq) and FIFO-fed UART (tx)
module io_periph
  import io_periph_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_r,
  input  logic        io_w,
  input  logic [15:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] cycle, cmp, cnt, stat;
  logic [15:0] wa, div, div_cnt;
  logic en, pending, ovf, match, tick, push, pop;
  logic wr_cmp, wr_ctrl, wr_cnt, wr_stat, wr_div;
  logic [7:0] sh, f_dout;
  logic [2:0] bit_cnt;
  logic f_full, f_empty;
  logic [CW-1:0] f_count;
  uart_state_t state;
  assign wa = io_addr & 16'hFFFC;
  assign wr_cmp = io_w && wa == IO_TIMER_CMP;
  assign wr_ctrl = io_w && wa == IO_TIMER_CTRL;
  assign wr_cnt = io_w && wa == IO_TIMER_CNT;
  assign push = io_w && wa == IO_UART_DATA;
  assign wr_stat = io_w && wa == IO_UART_STAT;
  assign wr_div = io_w && wa == IO_UART_DIV;
  assign match = en && cnt == cmp;
  assign tick = div_cnt == '0;
  assign pop = !f_empty && (state == UART_IDLE || (state == UART_STOP && tick));
  assign irq = pending;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(io_wdata[7:0]),
    .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
  );
  always_comb begin
    stat = '0;
    stat[STAT_FULL] = f_full;
    stat[STAT_EMPTY] = f_empty;
    stat[STAT_BUSY] = state != UART_IDLE;
    stat[STAT_OVF] = ovf;
    stat[STAT_CNT+:4] = 4'(f_count);
  end
  always_comb begin
    io_rdata = '0;
    if (io_r)
      case (wa)
        IO_CYCLE:      io_rdata = cycle;
        IO_TIMER_CMP:  io_rdata = cmp;
        IO_TIMER_CTRL: io_rdata = {30'b0, pending, en};
        IO_TIMER_CNT:  io_rdata = cnt;
        IO_UART_STAT:  io_rdata = stat;
        IO_UART_DIV:   io_rdata = {16'b0, div};
        default:       io_rdata = '0;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle <= '0;
      cmp <= '1;
      en <= 1'b0;
      pending <= 1'b0;
      cnt <= '0;
      div <= DIV_RESET;
      ovf <= 1'b0;
    end else begin
      cycle <= cycle + 1'b1;
      if (wr_cmp) cmp <= io_wdata;
      if (wr_ctrl) en <= io_wdata[0];
      if (wr_div) div <= io_wdata[15:0];
      pending <= match || (pending && !(wr_ctrl && io_wdata[1]));
      cnt <= wr_cnt ? io_wdata : match ? '0 : en ? cnt + 1'b1 : cnt;
      ovf <= (push && f_full) || (ovf && !(wr_stat && io_wdata[STAT_OVF]));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UART_IDLE;
      tx <= 1'b1;
      sh <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      div_cnt <= (state == UART_IDLE || tick) ? div : div_cnt - 1'b1;
      case (state)
        UART_IDLE:
          if (pop) begin
            state <= UART_START;
            sh <= f_dout;
            tx <= 1'b0;
            bit_cnt <= '0;
          end
        UART_START:
          if (tick) begin
            state <= UART_DATA;
            tx <= sh[0];
            sh <= sh >> 1;
          end
        UART_DATA:
          if (tick) begin
            state <= bit_cnt == 3'd7 ? UART_STOP : UART_DATA;
            tx <= bit_cnt == 3'd7 ? 1'b1 : sh[0];
            sh <= sh >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        UART_STOP:
          if (tick) begin
            state <= pop ? UART_START : UART_IDLE;
            tx <= !pop;
            if (pop) sh <= f_dout;
            bit_cnt <= '0;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_io_periph.sv
// tb_io_periph: randomized self-checking bench for io_periph against a queue/arithmetic reference model
module tb_io_periph;
  import io_periph_pkg::*;
  logic clk = 0, rst = 1, io_r = 0, io_w = 0, tx, irq;
  logic [15:0] io_addr = '0;
  logic [31:0] io_wdata = '0, io_rdata;
  int total = 0, bad = 0;
  io_periph dut (.clk(clk), .rst(rst), .io_r(io_r), .io_w(io_w), .io_addr(io_addr),
                 .io_wdata(io_wdata), .io_rdata(io_rdata), .tx(tx), .irq(irq));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    io_addr = a;
    io_wdata = d;
    io_w = 1;
    tick();
    io_w = 0;
  endtask
  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    io_addr = a;
    io_r = 1;
    #1;
    d = io_rdata;
    io_r = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
  endfunction
  task automatic test_reset();
    logic [31:0] c1, c2, v;
    do_reset();
    rd(IO_CYCLE, c1);
    total++; if (c1 !== 32'd0) begin bad++; $display("FAIL reset_cycle: got %h exp %h", c1, 32'd0); end
    repeat (3) tick();
    rd(IO_CYCLE, c2);
    total++; if (c2 !== c1 + 32'd3) begin bad++; $display("FAIL cycle_plus3: got %h exp %h", c2, c1 + 32'd3); end
    rd(IO_TIMER_CMP, v);
    total++; if (v !== 32'hFFFFFFFF) begin bad++; $display("FAIL reset_cmp: got %h exp ffffffff", v); end
    rd(IO_TIMER_CTRL, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got %h exp 0", v); end
    rd(IO_TIMER_CNT, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %h exp 0", v); end
    rd(IO_UART_STAT, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL reset_stat: got %h exp 2", v); end
    rd(IO_UART_DIV, v);
    total++; if (v !== 32'd867) begin bad++; $display("FAIL reset_div: got %0d exp 867", v); end
    total++; if (tx !== 1'b1 || irq !== 1'b0) begin bad++; $display("FAIL reset_pins: got tx=%b irq=%b exp tx=1 irq=0", tx, irq); end
  endtask
  task automatic test_timer();
    logic [31:0] v;
    int n;
    wr(IO_TIMER_CMP, 5);
    wr(IO_TIMER_CTRL, 1);
    n = 0;
    while (!irq && n < 20) begin tick(); n++; end
    total++; if (n != 6) begin bad++; $display("FAIL irq_delay: got %0d exp 6", n); end
    rd(IO_TIMER_CNT, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL cnt_at_irq: got %h exp 0", v); end
    rd(IO_TIMER_CTRL, v);
    total++; if (v !== 32'd3) begin bad++; $display("FAIL ctrl_pending: got %h exp 3", v); end
    wr(IO_TIMER_CTRL, 2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b exp 0", irq); end
    wr(IO_TIMER_CNT, 5);
    wr(IO_TIMER_CTRL, 1);
    wr(IO_TIMER_CTRL, 3);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL set_wins: got %b exp 1", irq); end
    wr(IO_TIMER_CTRL, 2);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear2: got %b exp 0", irq); end
  endtask
  task automatic test_timer_random();
    logic [31:0] v;
    int cmp, k, n;
    for (int it = 0; it < 4; it++) begin
      cmp = $urandom_range(1, 15);
      wr(IO_TIMER_CTRL, 2);
      wr(IO_TIMER_CTRL, 2);
      wr(IO_TIMER_CMP, cmp);
      wr(IO_TIMER_CNT, 0);
      wr(IO_TIMER_CTRL, 1);
      k = $urandom_range(0, cmp);
      repeat (k) tick();
      rd(IO_TIMER_CNT, v);
      total++; if (v !== 32'(k) || irq !== 1'b0) begin bad++; $display("FAIL timer_cnt_rand: got cnt=%0d irq=%b exp cnt=%0d irq=0", v, irq, k); end
      n = k;
      while (!irq && n < 100) begin tick(); n++; end
      total++; if (n != cmp + 1) begin bad++; $display("FAIL timer_rise_rand: got %0d exp %0d", n, cmp + 1); end
    end
    wr(IO_TIMER_CTRL, 2);
    wr(IO_TIMER_CTRL, 2);
  endtask
  task automatic test_rw();
    logic [31:0] v, d, old;
    for (int it = 0; it < 4; it++) begin
      d = $urandom;
      wr(IO_TIMER_CMP, d);
      rd(IO_TIMER_CMP, v);
      total++; if (v !== d) begin bad++; $display("FAIL rw_cmp: got %h exp %h", v, d); end
      d = $urandom;
      wr(IO_TIMER_CNT, d);
      rd(IO_TIMER_CNT, v);
      total++; if (v !== d) begin bad++; $display("FAIL rw_cnt: got %h exp %h", v, d); end
      d = $urandom;
      wr(IO_UART_DIV, d);
      rd(IO_UART_DIV, v);
      total++; if (v !== {16'b0, d[15:0]}) begin bad++; $display("FAIL rw_div: got %h exp %h", v, {16'b0, d[15:0]}); end
    end
    rd(IO_TIMER_CMP, old);
    d = ~old;
    io_addr = IO_TIMER_CMP;
    io_wdata = d;
    io_r = 1;
    io_w = 1;
    #1;
    v = io_rdata;
    total++; if (v !== old) begin bad++; $display("FAIL rw_same_cycle: got %h exp %h", v, old); end
    tick();
    io_r = 0;
    io_w = 0;
    #1;
    total++; if (io_rdata !== 32'd0) begin bad++; $display("FAIL no_strobe: got %h exp 0", io_rdata); end
    rd(16'h0007, v);
    total++; if (v !== d) begin bad++; $display("FAIL addr_low_bits: got %h exp %h", v, d); end
  endtask
  task automatic test_unmapped();
    logic [31:0] v, c0;
    logic [15:0] addrs [3] = '{16'h0020, 16'h001C, 16'h1000};
    for (int i = 0; i < 3; i++) begin
      wr(addrs[i], $urandom);
      rd(addrs[i], v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL unmapped_rd %h: got %h exp 0", addrs[i], v); end
    end
    rd(IO_CYCLE, c0);
    wr(IO_CYCLE, 32'h0);
    rd(IO_CYCLE, v);
    total++; if (v !== c0 + 32'd1) begin bad++; $display("FAIL cycle_ro: got %h exp %h", v, c0 + 32'd1); end
  endtask
  task automatic test_uart_frame(input logic [7:0] b);
    logic [31:0] v;
    wr(IO_UART_DIV, 3);
    wr(IO_UART_DATA, {24'b0, b});
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL frame_pre: got %b exp 1", tx); end
    for (int t = 1; t <= 40; t++) begin
      tick();
      total++; if (tx !== frame_bit(b, (t - 1) / 4)) begin bad++; $display("FAIL frame_bit t=%0d byte=%h: got %b exp %b", t, b, tx, frame_bit(b, (t - 1) / 4)); end
      if (t == 20) begin
        rd(IO_UART_STAT, v);
        total++; if (v[STAT_BUSY] !== 1'b1) begin bad++; $display("FAIL frame_busy: got %b exp 1", v[STAT_BUSY]); end
      end
    end
    tick();
    rd(IO_UART_STAT, v);
    total++; if (tx !== 1'b1 || v !== 32'h2) begin bad++; $display("FAIL frame_end: got tx=%b stat=%h exp tx=1 stat=2", tx, v); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] b [3];
    logic [31:0] v;
    logic e;
    int idx;
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    wr(IO_UART_DIV, 1);
    for (int t = 0; t <= 61; t++) begin
      io_w = t < 3;
      io_addr = IO_UART_DATA;
      io_wdata = t < 3 ? {24'b0, b[t]} : 32'b0;
      tick();
      if (t >= 1 && t <= 60) begin
        idx = t - 1;
        e = frame_bit(b[idx / 20], (idx % 20) / 2);
        total++; if (tx !== e) begin bad++; $display("FAIL b2b t=%0d: got %b exp %b", t, tx, e); end
      end
    end
    io_w = 0;
    rd(IO_UART_STAT, v);
    total++; if (tx !== 1'b1 || v !== 32'h2) begin bad++; $display("FAIL b2b_end: got tx=%b stat=%h exp tx=1 stat=2", tx, v); end
  endtask
  task automatic test_fifo();
    logic [7:0] q [$];
    logic [31:0] v, e;
    logic ovf;
    logic [7:0] d;
    ovf = 0;
    wr(IO_UART_DIV, 16'hFFFF);
    for (int k = 0; k < 11; k++) begin
      d = 8'($urandom);
      if (q.size() < 8) q.push_back(d); else ovf = 1;
      if (k == 1) void'(q.pop_front());
      wr(IO_UART_DATA, {24'b0, d});
      rd(IO_UART_STAT, v);
      e = (32'(q.size()) << 4) | (32'(ovf) << 3) | (32'(k >= 1) << 2) | (32'(q.size() == 0) << 1) | 32'(q.size() == 8);
      total++; if (v !== e) begin bad++; $display("FAIL fifo_stat k=%0d: got %h exp %h", k, v, e); end
    end
    wr(IO_UART_STAT, 32'h8);
    rd(IO_UART_STAT, v);
    total++; if (v !== 32'h85) begin bad++; $display("FAIL ovf_clear: got %h exp 85", v); end
    do_reset();
  endtask
  task automatic test_reset_mid();
    logic [31:0] v;
    int edges;
    wr(IO_UART_DIV, 3);
    wr(IO_UART_DATA, 32'h00);
    repeat (18) tick();
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_data: got %b exp 0", tx); end
    rst = 1;
    tick();
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_rst_tx: got %b exp 1", tx); end
    rst = 0;
    rd(IO_UART_STAT, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL mid_rst_stat: got %h exp 2", v); end
    rd(IO_UART_DIV, v);
    total++; if (v !== 32'd867) begin bad++; $display("FAIL mid_rst_div: got %0d exp 867", v); end
    edges = 0;
    repeat (60) begin tick(); if (tx !== 1'b1) edges++; end
    total++; if (edges != 0) begin bad++; $display("FAIL mid_rst_quiet: got %0d low cycles exp 0", edges); end
  endtask
  initial begin
    test_reset();
    test_timer();
    test_timer_random();
    test_rw();
    test_unmapped();
    test_uart_frame(8'hA5);
    test_uart_frame(8'($urandom));
    test_uart_frame(8'($urandom));
    test_back_to_back();
    test_fifo();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
